// File: rtl/grf_scoreboard_pkg.sv
// grf_scoreboard_pkg: shared constants for the GRF scoreboard (register count, counter/timer widths, default in-flight limit)
package grf_scoreboard_pkg;
   localparam int NREG = 32;
   localparam int CNT_W = 2;
   localparam int TMR_W = 2;
   localparam int MAX_INFLIGHT_DEF = 3;
endpackage

// File: rtl/grf_scoreboard_sb_entry.sv
// grf_sb_entry: pending-write counter and ready timer for one GRF register
// Ports: clk, reset, flush; iss = accepted issue writing this register, lat = its latency;
// wb = writeback to this register; cnt = pending writes; hazard = source must stall; full = cnt at limit.
// Build option GRF_SB_FORWARD_EN: hazard follows the ready timer instead of the pending counter.
module grf_sb_entry import grf_scoreboard_pkg::*; #(
   parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             iss,
   input  logic             wb,
   input  logic [TMR_W-1:0] lat,
   output logic [CNT_W-1:0] cnt,
   output logic             hazard,
   output logic             full
);
   logic [CNT_W-1:0] cnt_n;
   logic [TMR_W-1:0] tmr, tmr_n;
   // an issue and a writeback in the same cycle cancel; a writeback at zero stays at zero
   always_comb begin
      cnt_n = (iss & wb) ? cnt : iss ? cnt + 1'b1 : (wb & cnt != '0) ? cnt - 1'b1 : cnt;
      tmr_n = (cnt_n == '0) ? '0 : iss ? lat : (tmr != '0) ? tmr - 1'b1 : tmr;
   end
   always_ff @(posedge clk) begin
      if (reset | flush) begin
         cnt <= '0;
         tmr <= '0;
      end else begin
         cnt <= cnt_n;
         tmr <= tmr_n;
      end
   end
   assign full = cnt == CNT_W'(MAX_INFLIGHT);
`ifdef GRF_SB_FORWARD_EN
   assign hazard = tmr != '0;
`else
   assign hazard = cnt != '0;
`endif
endmodule

// File: rtl/grf_scoreboard.sv
// grf_scoreboard: per-register write scoreboard generating decode stall, busy vector and protocol error
// Ports: clk, reset; issue_* = decode-stage instruction; wb_valid/wb_dst = committed GRF write;
// flush = drop all tracking; stall (comb), busy (registered), err (registered, sticky).
// Build option GRF_SB_FORWARD_EN: sources stall only until the producer result is forwardable.
module grf_scoreboard import grf_scoreboard_pkg::*; #(
   parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             issue_valid,
   input  logic [4:0]       issue_rs,
   input  logic [4:0]       issue_rt,
   input  logic             use_rs,
   input  logic             use_rt,
   input  logic             issue_we,
   input  logic [4:0]       issue_dst,
   input  logic [TMR_W-1:0] issue_lat,
   input  logic             wb_valid,
   input  logic [4:0]       wb_dst,
   input  logic             flush,
   output logic             stall,
   output logic [NREG-1:0]  busy,
   output logic             err
);
   logic [CNT_W-1:0] cnt [NREG];
   logic [NREG-1:0]  haz, full, nz;
   logic             acc;
   // register 0 has no entry, so its hazard/full bits are tied low
   assign cnt[0]  = '0;
   assign haz[0]  = 1'b0;
   assign full[0] = 1'b0;
   assign nz[0]   = 1'b0;
   assign stall = issue_valid & ~flush & ((use_rs & haz[issue_rs]) | (use_rt & haz[issue_rt]) | (issue_we & full[issue_dst]));
   assign acc = issue_valid & ~stall & ~flush;
   for (genvar i = 1; i < NREG; i++) begin : g_ent
      grf_sb_entry #(.MAX_INFLIGHT(MAX_INFLIGHT)) u_ent (
         .clk    (clk),
         .reset  (reset),
         .flush  (flush),
         .iss    (acc & issue_we & (issue_dst == 5'(i))),
         .wb     (wb_valid & (wb_dst == 5'(i))),
         .lat    (issue_lat),
         .cnt    (cnt[i]),
         .hazard (haz[i]),
         .full   (full[i])
      );
      assign nz[i] = cnt[i] != '0;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         busy <= '0;
         err  <= 1'b0;
      end else begin
         busy <= nz;
         if (~flush & wb_valid & (wb_dst != '0) & (cnt[wb_dst] == '0))
            err <= 1'b1;
      end
   end
endmodule

// File: tb/tb_grf_scoreboard.sv
// tb_grf_scoreboard: directed self-checking bench for grf_scoreboard
module tb_grf_scoreboard;
`ifdef GRF_SB_FORWARD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif
   logic        clk = 1'b0;
   logic        reset, issue_valid, use_rs, use_rt, issue_we, wb_valid, flush;
   logic [4:0]  issue_rs, issue_rt, issue_dst, wb_dst;
   logic [1:0]  issue_lat;
   logic        stall, err;
   logic [31:0] busy;
   int checks = 0;
   int errors = 0;

   grf_scoreboard dut (
      .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_rs(issue_rs), .issue_rt(issue_rt),
      .use_rs(use_rs), .use_rt(use_rt), .issue_we(issue_we), .issue_dst(issue_dst), .issue_lat(issue_lat),
      .wb_valid(wb_valid), .wb_dst(wb_dst), .flush(flush), .stall(stall), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   task tick;
      @(posedge clk);
      #1;
   endtask

   task idle;
      issue_valid = 0; use_rs = 0; use_rt = 0; issue_we = 0; wb_valid = 0; flush = 0;
      issue_rs = 0; issue_rt = 0; issue_dst = 0; wb_dst = 0; issue_lat = 0;
   endtask

   task put_issue(input logic [4:0] dst, input logic [1:0] lat);
      issue_valid = 1; issue_we = 1; issue_dst = dst; issue_lat = lat; use_rs = 0; use_rt = 0;
   endtask

   task test_reset;
      idle; reset = 1; issue_valid = 1; use_rs = 1; issue_rs = 5;
      tick; tick;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall); end
      checks++; if (busy !== 32'h0) begin errors++; $display("FAIL reset_busy got %h want 0", busy); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
      reset = 0; idle;
   endtask

   task test_forward;
      idle; put_issue(5, 2);
      #1 checks++; if (stall !== 1'b0) begin errors++; $display("FAIL fwd_issue got %b want 0", stall); end
      tick;
      issue_we = 0; use_rs = 1; issue_rs = 5;
      #1 checks++; if (stall !== 1'b1) begin errors++; $display("FAIL fwd_k0 got %b want 1", stall); end
      checks++; if (busy[5] !== 1'b0) begin errors++; $display("FAIL busy_lag0 got %b want 0", busy[5]); end
      tick;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL fwd_k1 got %b want 1", stall); end
      checks++; if (busy[5] !== 1'b1) begin errors++; $display("FAIL busy_lag1 got %b want 1", busy[5]); end
      tick;
      checks++; if (stall !== !FWD) begin errors++; $display("FAIL fwd_k2 got %b want %b", stall, !FWD); end
      wb_valid = 1; wb_dst = 5;
      #1 checks++; if (stall !== !FWD) begin errors++; $display("FAIL fwd_wb got %b want %b", stall, !FWD); end
      tick;
      wb_valid = 0;
      #1 checks++; if (stall !== 1'b0) begin errors++; $display("FAIL fwd_after_wb got %b want 0", stall); end
      checks++; if (busy[5] !== 1'b1) begin errors++; $display("FAIL busy_lag_wb got %b want 1", busy[5]); end
      idle; tick;
      checks++; if (busy[5] !== 1'b0) begin errors++; $display("FAIL busy_clear got %b want 0", busy[5]); end
   endtask

   task test_full;
      idle;
      for (int i = 0; i < 3; i++) begin
         put_issue(7, 0);
         #1 checks++; if (stall !== 1'b0) begin errors++; $display("FAIL full_issue%0d got %b want 0", i, stall); end
         tick;
      end
      put_issue(7, 0);
      #1 checks++; if (stall !== 1'b1) begin errors++; $display("FAIL full_4th got %b want 1", stall); end
      tick;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL full_hold got %b want 1", stall); end
      wb_valid = 1; wb_dst = 7;
      #1 checks++; if (stall !== 1'b1) begin errors++; $display("FAIL full_wb_cycle got %b want 1", stall); end
      tick;
      wb_valid = 0;
      #1 checks++; if (stall !== 1'b0) begin errors++; $display("FAIL full_accept got %b want 0", stall); end
      tick;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL full_cnt3 got %b want 1", stall); end
      flush = 1;
      #1 checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_mask got %b want 0", stall); end
      tick; idle;
   endtask

   task test_same_cycle;
      idle; put_issue(9, 1);
      tick;
      wb_valid = 1; wb_dst = 9;
      #1 checks++; if (stall !== 1'b0) begin errors++; $display("FAIL same_stall got %b want 0", stall); end
      tick;
      wb_valid = 0; issue_we = 0; use_rs = 1; issue_rs = 9;
      #1 checks++; if (stall !== 1'b1) begin errors++; $display("FAIL same_haz got %b want 1", stall); end
      tick;
      checks++; if (stall !== !FWD) begin errors++; $display("FAIL same_tmr got %b want %b", stall, !FWD); end
      checks++; if (busy[9] !== 1'b1) begin errors++; $display("FAIL same_busy got %b want 1", busy[9]); end
      put_issue(9, 0);
      #1 checks++; if (stall !== 1'b0) begin errors++; $display("FAIL same_probe1 got %b want 0", stall); end
      tick;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL same_probe2 got %b want 0", stall); end
      tick;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL same_probe3 got %b want 1", stall); end
      idle; flush = 1; tick; idle;
   endtask

   task test_err;
      idle;
      #1 checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_init got %b want 0", err); end
      wb_valid = 1; wb_dst = 4;
      tick;
      wb_valid = 0;
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_set got %b want 1", err); end
      flush = 1; tick; flush = 0; tick;
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", err); end
      checks++; if (busy[4] !== 1'b0) begin errors++; $display("FAIL err_busy got %b want 0", busy[4]); end
      put_issue(4, 0);
      #1 checks++; if (stall !== 1'b0) begin errors++; $display("FAIL err_cnt0 got %b want 0", stall); end
      idle;
   endtask

   task test_zero_flush;
      idle; put_issue(0, 0); use_rs = 1; issue_rs = 0; use_rt = 1; issue_rt = 0;
      for (int i = 0; i < 4; i++) begin
         #1 checks++; if (stall !== 1'b0) begin errors++; $display("FAIL zero_stall%0d got %b want 0", i, stall); end
         tick;
      end
      checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL zero_busy got %b want 0", busy[0]); end
      for (int d = 1; d <= 3; d++) begin
         put_issue(5'(d), 1);
         tick;
      end
      idle; tick;
      checks++; if (busy !== 32'h0000_000E) begin errors++; $display("FAIL pend_busy got %h want 0000000e", busy); end
      flush = 1; put_issue(6, 0);
      #1 checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall got %b want 0", stall); end
      tick;
      idle; tick;
      checks++; if (busy !== 32'h0) begin errors++; $display("FAIL flush_busy got %h want 0", busy); end
      issue_valid = 1; use_rs = 1; issue_rs = 1;
      #1 checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_cleared got %b want 0", stall); end
      idle;
   endtask

   task test_reset_override;
      idle; put_issue(10, 3);
      tick; idle; tick;
      reset = 1; put_issue(11, 0); wb_valid = 1; wb_dst = 10;
      tick;
      reset = 0; idle;
      checks++; if (busy !== 32'h0) begin errors++; $display("FAIL rst_busy got %h want 0", busy); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", err); end
      issue_valid = 1; use_rs = 1; issue_rs = 10; use_rt = 1; issue_rt = 11;
      #1 checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_cnt got %b want 0", stall); end
      idle; tick;
   endtask

   initial begin
      test_reset;
      test_forward;
      test_full;
      test_same_cycle;
      test_err;
      test_zero_flush;
      test_reset_override;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/grf_scoreboard.md
GRF_SCOREBOARD -- requirements
Module: grf_scoreboard

Interface
REQ-001 SHALL have parameter MAX_INFLIGHT, default 3; maximum outstanding writes tracked per register (2-bit counter).
REQ-002 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port issue_valid  in  1  decode stage presents an instruction.
REQ-005 SHALL have ports issue_rs, issue_rt  in  5 each  source register numbers.
REQ-006 SHALL have ports use_rs, use_rt  in  1 each  instruction actually reads rs / rt.
REQ-007 SHALL have ports issue_we  in  1, issue_dst  in  5  instruction writes GRF register issue_dst.
REQ-008 SHALL have port issue_lat  in  2  cycles after issue until the result is forwardable (0..3).
REQ-009 SHALL have ports wb_valid  in  1, wb_dst  in  5  GRF write committed this cycle.
REQ-010 SHALL have port flush  in  1  discard all in-flight tracking.
REQ-011 SHALL have port stall  out  1  combinational; decode must hold the instruction.
REQ-012 SHALL have port busy  out  32  registered; bit r = cnt[r] != 0.
REQ-013 SHALL have port err  out  1  registered, sticky protocol-error flag.

Function
REQ-014 SHALL keep per register r a pending counter cnt[r] (0..MAX_INFLIGHT) and a ready timer tmr[r] (0..3).
REQ-015 SHALL treat register 0 as never pending: cnt[0] and tmr[0] stay 0; rs/rt/dst of 0 never cause a stall.
REQ-016 SHALL define hazard(r) as tmr[r] != 0 when SB_FORWARD_EN is defined, else cnt[r] != 0.
REQ-017 SHALL assert stall = issue_valid & !flush & ((use_rs & rs!=0 & hazard(rs)) | (use_rt & rt!=0 & hazard(rt)) | (issue_we & dst!=0 & cnt[dst]==MAX_INFLIGHT)).
REQ-018 SHALL accept an issue when issue_valid & !stall & !flush; then, if issue_we & dst!=0: cnt[dst] increments and tmr[dst] loads issue_lat.
REQ-019 SHALL decrement every nonzero tmr by 1 each cycle, except a timer loaded that cycle.
REQ-020 SHALL decrement cnt[wb_dst] when wb_valid & wb_dst!=0.
REQ-021 SHALL, on accepted issue and writeback to the same register in one cycle, leave cnt unchanged and load tmr with issue_lat.
REQ-022 SHALL, on writeback to a register with cnt==0, leave cnt at 0 and set err.
REQ-023 SHALL clear tmr[r] when cnt[r] goes to 0.
REQ-024 SHALL, when flush is high, clear all cnt and tmr next edge, ignoring issue and wb that cycle; err is unaffected.
REQ-025 SHALL update busy one cycle after the cnt change that causes it.

Reset
REQ-026 SHALL on reset clear all cnt, tmr, busy and err to 0; reset overrides flush, issue and wb.
REQ-027 SHALL produce stall = 0 during reset whenever issue_valid is low; stall remains combinational from cleared state.

Configuration
REQ-028 SHALL compile forwarding-aware hazard detection only when macro GRF_SB_FORWARD_EN is defined: stall only while the producer's result is not yet forwardable (tmr != 0).
REQ-029 SHALL, without GRF_SB_FORWARD_EN, stall on any pending write to a source (cnt != 0); tmr logic may be removed.

Structure
REQ-030 SHALL place MAX_INFLIGHT default, the timer width and the register-count constant (32) in the shared pipeline package.
REQ-031 SHALL implement one sub-module, grf_sb_entry, holding one register's cnt/tmr with issue/wb/flush inputs; instantiated for registers 1..31.

Verification
REQ-032 Issue we dst=5 lat=2, next cycle use_rs rs=5: with _EN stall high 2 cycles then low; without _EN stall until wb_dst=5.
REQ-033 Three issues to dst=7 without wb, fourth issue to dst=7 -> stall high; wb_dst=7 -> fourth accepted next cycle, cnt[7]=3.
REQ-034 Same-cycle issue dst=9 lat=1 and wb_dst=9 with cnt[9]=1 -> cnt[9] stays 1, tmr[9]=1, busy[9]=1.
REQ-035 wb_valid wb_dst=4 with cnt[4]=0 -> err=1 and stays 1 until reset; cnt[4]=0.
REQ-036 Issue dst=0 and use_rs rs=0 -> never stall, busy[0]=0; flush with 3 registers pending -> busy=0 next cycle, issue that cycle ignored.
